conf_int_mul_seq_ctrl: RTL and testbench
========================================

CONF_INT_MUL_SEQ_CTRL -- requirements
Module: conf_int_mul_seq_ctrl

Interface
REQ-001 SHALL have parameter APX_LEN, default 4: number of cycles spent in state 3'b010 (APX), range 1..511.
REQ-002 SHALL have parameter ACC_LEN, default 4: number of cycles spent in state 3'b011 (ACC), range 1..511.
REQ-003 SHALL have parameter PIPE_LAT, default 3: cycles from state issue to valid P from the multiplier wrapper, and the FLUSH length; range 1..7.
REQ-004 SHALL have port clk, input, 1: the single clock; all flops are clocked on its rising edge.
REQ-005 SHALL have port racc, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1: request a run; sampled only in IDLE.
REQ-007 SHALL have port apx_en, input, 1: approximate-mode select; latched on accepted start.
REQ-008 SHALL have port abort, input, 1: synchronous run cancel.
REQ-009 SHALL have port P, input, 32: product from the multiplier wrapper.
REQ-010 SHALL have port state_fb, input, 3: state echoed back by the wrapper.
REQ-011 SHALL have port state_out, output, 3: drives the wrapper state input.
REQ-012 SHALL have port count0, output, 9: phase counter; drives the wrapper count0.
REQ-013 SHALL have port rapx, output, 1: approximate-bit control to the wrapper.
REQ-014 SHALL have port rstP, output, 1: synchronous clear of the wrapper's P register.
REQ-015 SHALL have port busy, output, 1: high whenever state_out != IDLE.
REQ-016 SHALL have port result, output, 32: last valid P captured.
REQ-017 SHALL have port result_valid, output, 1: one-cycle pulse when result is updated.
REQ-018 SHALL have port done, output, 1: one-cycle pulse at normal run completion.
REQ-019 SHALL have port fb_err, output, 1: sticky state-echo mismatch flag.

Function
REQ-020 SHALL implement the encodings IDLE=000, LOAD=001, APX=010, ACC=011, FLUSH=100; state_out SHALL equal the current state register.
REQ-021 IDLE with start=1 and abort=0 SHALL go to LOAD on the next cycle, SHALL latch apx_en into rapx, and SHALL clear fb_err.
REQ-022 count0 SHALL be 0 on entry to every state and SHALL increment by 1 each cycle within the state.
REQ-023 LOAD SHALL last exactly 64 cycles; the transition to APX SHALL occur in the cycle after count0==63.
REQ-024 APX SHALL last APX_LEN cycles and ACC SHALL last ACC_LEN cycles; the exit condition is count0==LEN-1.
REQ-025 FLUSH SHALL last PIPE_LAT cycles and then return to IDLE.
REQ-026 done SHALL pulse in the first IDLE cycle after FLUSH.
REQ-027 count0 SHALL hold 0 in IDLE.
REQ-028 rapx SHALL hold its latched value for the whole run and SHALL be 0 in IDLE.
REQ-029 rstP SHALL be 1 in IDLE and 0 in all other states.
REQ-030 An issue-tag shift register PIPE_LAT deep SHALL be loaded with 1 when state_out is APX or ACC, and with 0 otherwise.
REQ-031 When the tag output is 1, result SHALL load P and result_valid SHALL pulse in the same cycle.
REQ-032 abort=1 in any non-IDLE state SHALL force IDLE next cycle; done SHALL stay 0.
REQ-033 abort SHALL clear the tag pipeline so that no result_valid follows.
REQ-034 abort SHALL take priority over every other transition; abort in IDLE SHALL have no effect.
REQ-035 start asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-036 start and abort both high in IDLE SHALL leave the block in IDLE.
REQ-037 fb_err SHALL set when busy and state_fb differs from state_out delayed by one cycle (the wrapper's register latency).
REQ-038 The fb_err check SHALL be masked for the first cycle after leaving IDLE.

Reset
REQ-039 racc=1 SHALL asynchronously force: state_out=IDLE, count0=0, rapx=0, rstP=1, busy=0, result=0, result_valid=0, done=0, fb_err=0, tag pipeline=0.
REQ-040 racc asserted mid-run SHALL abandon the run with no done pulse.
REQ-041 After racc deassertion the block SHALL accept start from the first clock edge.

Verification
REQ-042 Default parameters, start=1 at cycle 0, apx_en=0 -> state_out=001 over cycles 1-64 (count0 0..63), 010 over 65-68, 011 over 69-72, 100 over 73-75; done=1 at 76; busy high 1-75; rapx=0 throughout.
REQ-043 Same run with apx_en=1 and P=cycle number -> rapx=1 over 1-75; result_valid pulses at 68-75; final result=75.
REQ-044 abort=1 at cycle 66 -> state_out=000 at 67; done never pulses; no result_valid after 67.
REQ-045 start re-pulsed at cycles 10 and 40 during a run -> timeline identical to REQ-042 with exactly one done.
REQ-046 racc pulsed at cycle 70 -> all outputs at reset values immediately; a start at cycle 80 runs a full sequence ending with done at 156.
REQ-047 state_fb stuck at 000 during a run -> fb_err=1 from cycle 3 and held until the next accepted start.

Source files
------------

// File: rtl/conf_int_mul_seq_ctrl.sv
// rtl/conf_int_mul_seq_ctrl.sv - sequencing controller for a configurable integer multiplier wrapper
//
// Steps the wrapper through IDLE -> LOAD -> APX -> ACC -> FLUSH -> IDLE,
// tracks issued products through a tag pipeline and captures valid P values.
//
// Ports:
//   clk          - rising-edge clock
//   racc         - asynchronous active-high reset
//   start        - run request, sampled only in IDLE
//   apx_en       - approximate-mode select, latched on accepted start
//   abort        - synchronous run cancel
//   P            - product from the wrapper
//   state_fb     - state echoed back by the wrapper (one cycle late)
//   state_out    - state driven to the wrapper
//   count0       - per-state phase counter
//   rapx         - approximate-bit control
//   rstP         - clear of the wrapper P register (high in IDLE)
//   busy         - high whenever not in IDLE
//   result       - last valid product captured
//   result_valid - pulse while a tagged product is being captured
//   done         - pulse in the first IDLE cycle after FLUSH
//   fb_err       - sticky state-echo mismatch flag

module conf_int_mul_seq_ctrl #(
  parameter int APX_LEN  = 4,
  parameter int ACC_LEN  = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic        clk,
  input  logic        racc,
  input  logic        start,
  input  logic        apx_en,
  input  logic        abort,
  input  logic [31:0] P,
  input  logic [2:0]  state_fb,
  output logic [2:0]  state_out,
  output logic [8:0]  count0,
  output logic        rapx,
  output logic        rstP,
  output logic        busy,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        done,
  output logic        fb_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_LOAD  = 3'b001,
    S_APX   = 3'b010,
    S_ACC   = 3'b011,
    S_FLUSH = 3'b100
  } state_t;

  localparam logic [8:0] LOAD_LAST  = 9'd63;
  localparam logic [8:0] APX_LAST   = 9'(APX_LEN - 1);
  localparam logic [8:0] ACC_LAST   = 9'(ACC_LEN - 1);
  localparam logic [8:0] FLUSH_LAST = 9'(PIPE_LAT - 1);

  state_t              state_q, state_d;
  logic [8:0]          count_q, count_d;
  logic                rapx_q;
  logic                done_q;
  logic                fb_err_q;
  logic [2:0]          state_dly_q;
  logic [31:0]         result_q;
  logic [PIPE_LAT-1:0] tag_q, tag_d;
  logic                phase_last;
  logic                accept;
  logic                issue;
  logic                in_idle;

  assign in_idle = (state_q == S_IDLE);
  assign accept  = in_idle && start && !abort;
  assign issue   = (state_q == S_APX) || (state_q == S_ACC);

  always_comb begin
    phase_last = 1'b0;
    state_d    = state_q;
    count_d    = count_q + 9'd1;
    case (state_q)
      S_LOAD:  phase_last = (count_q == LOAD_LAST);
      S_APX:   phase_last = (count_q == APX_LAST);
      S_ACC:   phase_last = (count_q == ACC_LAST);
      S_FLUSH: phase_last = (count_q == FLUSH_LAST);
      default: phase_last = 1'b0;
    endcase

    if (in_idle) begin
      count_d = 9'd0;
      if (accept) state_d = S_LOAD;
    end else if (abort) begin
      state_d = S_IDLE;
      count_d = 9'd0;
    end else if (phase_last) begin
      count_d = 9'd0;
      case (state_q)
        S_LOAD:  state_d = S_APX;
        S_APX:   state_d = S_ACC;
        S_ACC:   state_d = S_FLUSH;
        default: state_d = S_IDLE;
      endcase
    end else if (state_q > S_FLUSH) begin
      // Unused encodings fall back to IDLE rather than lock up.
      state_d = S_IDLE;
      count_d = 9'd0;
    end

    // Abort empties the tag pipeline so in-flight products never report.
    tag_d    = tag_q << 1;
    tag_d[0] = issue;
    if (!in_idle && abort) tag_d = '0;
  end

  always_ff @(posedge clk or posedge racc) begin
    if (racc) begin
      state_q     <= S_IDLE;
      count_q     <= 9'd0;
      rapx_q      <= 1'b0;
      done_q      <= 1'b0;
      fb_err_q    <= 1'b0;
      state_dly_q <= 3'b000;
      result_q    <= 32'd0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      tag_q       <= tag_d;
      state_dly_q <= state_q;
      done_q      <= (state_q == S_FLUSH) && phase_last && !abort;

      if (accept)
        rapx_q <= apx_en;
      else if (state_d == S_IDLE)
        rapx_q <= 1'b0;

      if (tag_q[PIPE_LAT-1])
        result_q <= P;

      // state_dly_q == IDLE only in the first cycle after leaving IDLE,
      // where the wrapper has not yet echoed the new state.
      if (accept)
        fb_err_q <= 1'b0;
      else if (!in_idle && (state_dly_q != S_IDLE) && (state_fb != state_dly_q))
        fb_err_q <= 1'b1;
    end
  end

  assign state_out    = state_q;
  assign count0       = count_q;
  assign rapx         = rapx_q;
  assign rstP         = in_idle;
  assign busy         = !in_idle;
  assign result       = result_q;
  assign result_valid = tag_q[PIPE_LAT-1];
  assign done         = done_q;
  assign fb_err       = fb_err_q;

endmodule

// File: tb/tb_conf_int_mul_seq_ctrl.sv
// tb/tb_conf_int_mul_seq_ctrl.sv - self-checking bench for conf_int_mul_seq_ctrl
module tb_conf_int_mul_seq_ctrl;

  localparam int A   = 4;
  localparam int C   = 4;
  localparam int L   = 3;
  localparam int TOT = 64 + A + C + L;

  logic        clk = 1'b0;
  logic        racc, start, apx_en, abort;
  logic [31:0] P;
  logic [2:0]  state_fb;
  logic [2:0]  state_out;
  logic [8:0]  count0;
  logic        rapx, rstP, busy, result_valid, done, fb_err;
  logic [31:0] result;

  conf_int_mul_seq_ctrl #(.APX_LEN(A), .ACC_LEN(C), .PIPE_LAT(L)) dut (
    .clk(clk), .racc(racc), .start(start), .apx_en(apx_en), .abort(abort),
    .P(P), .state_fb(state_fb), .state_out(state_out), .count0(count0),
    .rapx(rapx), .rstP(rstP), .busy(busy), .result(result),
    .result_valid(result_valid), .done(done), .fb_err(fb_err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cur_sc, cur_c;

  // Model state
  int          t0;
  bit          apx_m, fb_m, done_m;
  int          res_m;
  bit          vld_at [0:255];
  logic [2:0]  prev_so;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s sc%0d cycle %0d got %0d expected %0d", nm, cur_sc, cur_c, got, exp);
    end
  endtask

  function automatic int ph_state(input int o);
    if (o < 0)          return 0;
    if (o < 64)         return 1;
    if (o < 64 + A)     return 2;
    if (o < 64 + A + C) return 3;
    if (o < TOT)        return 4;
    return 0;
  endfunction

  function automatic int ph_cnt(input int o);
    if (o < 0)          return 0;
    if (o < 64)         return o;
    if (o < 64 + A)     return o - 64;
    if (o < 64 + A + C) return o - 64 - A;
    if (o < TOT)        return o - 64 - A - C;
    return 0;
  endfunction

  task automatic model_clear();
    t0 = -1; apx_m = 0; fb_m = 0; done_m = 0; res_m = 0;
    for (int i = 0; i < 256; i++) vld_at[i] = 0;
  endtask

  task automatic stim(input int sc, input int c, output bit s, output bit a,
                      output bit ab, output bit r, output bit stk);
    s = 0; a = 0; ab = 0; r = 0; stk = 0;
    case (sc)
      0: s = (c == 0);
      1: begin s = (c == 0); a = 1; end
      2: begin s = (c == 0); a = 1; ab = (c == 66); end
      3: s = (c == 0) || (c == 10) || (c == 40);
      4: begin s = (c == 0) || (c == 80); r = (c == 70); a = (c >= 80); end
      5: begin s = (c == 0) || (c == 85); stk = 1; end
      default: begin
        s = (c == 0) || (c == 10); a = 1;
        ab = (c == 0) || (c == 5) || (c == 84);
      end
    endcase
  endtask

  task automatic literal_checks(input int sc, input int c);
    case (sc)
      0: begin
        if (c == 64) begin chk("lit_st64", state_out, 1); chk("lit_cnt64", count0, 63); end
        if (c == 65) chk("lit_st65", state_out, 2);
        if (c == 75) chk("lit_st75", state_out, 4);
        if (c == 76) chk("lit_done76", done, 1);
      end
      1: begin
        if (c == 67) chk("lit_rv67", result_valid, 0);
        if (c == 68) chk("lit_rv68", result_valid, 1);
        if (c == 76) chk("lit_res76", result, 75);
      end
      2: begin
        if (c == 67) chk("lit_abort_st67", state_out, 0);
        if (c == 68) chk("lit_abort_rv68", result_valid, 0);
      end
      3: if (c == 76) chk("lit_restart_done76", done, 1);
      4: begin
        if (c == 70) begin chk("lit_rst_st70", state_out, 0); chk("lit_rst_busy70", busy, 0); end
        if (c == 156) chk("lit_rst_done156", done, 1);
      end
      5: begin
        if (c == 2)  chk("lit_fb2", fb_err, 0);
        if (c == 3)  chk("lit_fb3", fb_err, 1);
        if (c == 86) chk("lit_fb86", fb_err, 0);
      end
      default: begin
        if (c == 1)  chk("lit_sa_busy1", busy, 0);
        if (c == 6)  chk("lit_ab_idle_busy6", busy, 0);
        if (c == 11) chk("lit_st11", state_out, 1);
      end
    endcase
  endtask

  task automatic run_scen(input int sc, input int ncyc);
    bit s, a, ab, r, stk;
    int o, est, ecnt;
    cur_sc = sc;
    @(negedge clk);
    racc = 1; start = 0; apx_en = 0; abort = 0; P = 0; state_fb = 0;
    @(posedge clk);
    model_clear();
    prev_so = 3'b000;
    for (int c = 0; c < ncyc; c++) begin
      cur_c = c;
      @(negedge clk);
      stim(sc, c, s, a, ab, r, stk);
      racc = r; start = s; apx_en = a; abort = ab; P = c;
      state_fb = stk ? 3'b000 : prev_so;
      #1;
      if (r) begin
        chk("state_out", state_out, 0);
        chk("count0", count0, 0);
        chk("rapx", rapx, 0);
        chk("rstP", rstP, 1);
        chk("busy", busy, 0);
        chk("result", result, 0);
        chk("result_valid", result_valid, 0);
        chk("done", done, 0);
        chk("fb_err", fb_err, 0);
      end else begin
        o    = (t0 >= 0) ? c - t0 : -1;
        est  = ph_state(o);
        ecnt = ph_cnt(o);
        chk("state_out", state_out, est);
        chk("count0", count0, ecnt);
        chk("rapx", rapx, (t0 >= 0) ? apx_m : 0);
        chk("rstP", rstP, (t0 >= 0) ? 0 : 1);
        chk("busy", busy, (t0 >= 0) ? 1 : 0);
        chk("result", result, res_m);
        chk("result_valid", result_valid, vld_at[c]);
        chk("done", done, done_m);
        chk("fb_err", fb_err, fb_m);
      end
      literal_checks(sc, c);
      prev_so = state_out;

      // Advance the model across the coming clock edge.
      if (r) begin
        model_clear();
      end else begin
        if (vld_at[c]) res_m = c;
        done_m = 0;
        if (t0 >= 0) begin
          o = c - t0;
          if (o >= 1 && state_fb != 3'(ph_state(o - 1))) fb_m = 1;
          if (ab) begin
            t0 = -1;
            for (int i = c + 1; i < 256; i++) vld_at[i] = 0;
          end else begin
            if (ph_state(o) == 2 || ph_state(o) == 3) vld_at[c + L] = 1;
            if (o == TOT - 1) begin t0 = -1; done_m = 1; end
          end
        end else if (s && !ab) begin
          t0 = c + 1; apx_m = a; fb_m = 0;
        end
      end
      @(posedge clk);
    end
  endtask

  initial begin
    racc = 1; start = 0; apx_en = 0; abort = 0; P = 0; state_fb = 0;
    repeat (2) @(posedge clk);
    run_scen(0, 80);
    run_scen(1, 80);
    run_scen(2, 80);
    run_scen(3, 80);
    run_scen(4, 160);
    run_scen(5, 90);
    run_scen(6, 100);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
